multicycle_control: RTL and testbench

- Multi-cycle control FSM for the PA3 CPU. It sequences the shared datapath (PC, IR, register file, ALU, data memory) through fetch, decode, execute, memory and writeback steps.
- Uses the same opcode set and ALUOp encoding as the single-cycle decoder: R-type, addiu, subiu, sw, lw.
- Adds ready handshakes to instruction and data memory, a memory-timeout trap and a retired-instruction counter.

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/ctrl_out_decode.sv | 39 +++
 rtl/multicycle_control.sv | 132 +++++++++++++
 tb/tb_multicycle_control.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the PA3 multi-cycle controller: states, opcodes, ALUOp
// values and the strobe bundle driven by the output decoder.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_WB_I     = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_TRAP     = 4'd10
  } state_e;

  localparam logic [5:0] OP_R     = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd12;
  localparam logic [5:0] OP_SUBIU = 6'd13;
  localparam logic [5:0] OP_SW    = 6'd16;
  localparam logic [5:0] OP_LW    = 6'd17;

  localparam logic [1:0] ALU_SUB = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  // fetch_en marks the FETCH state; PCWrite/IRWrite are it qualified by imem_ready.
  typedef struct packed {
    logic       imem_req;
    logic       fetch_en;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{imem_req: 1'b0, fetch_en: 1'b0, reg_write: 1'b0,
                                  alu_op: ALU_ADD, reg_dst: 1'b0, alu_src: 1'b0,
                                  mem_write: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0,
                                  illegal: 1'b0};

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode: current state (and latched opcode for EXEC_I) to strobes.
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.imem_req = 1'b1;
        ctrl_o.fetch_en = 1'b1;
      end
      ST_EXEC_R: ctrl_o.alu_op = ALU_R;
      ST_EXEC_I: begin
        ctrl_o.alu_src = 1'b1;
        ctrl_o.alu_op  = (op_i == OP_SUBIU) ? ALU_SUB : ALU_ADD;
      end
      ST_MEM_ADDR: ctrl_o.alu_src = 1'b1;
      ST_MEM_RD:   ctrl_o.mem_read = 1'b1;
      ST_MEM_WR:   ctrl_o.mem_write = 1'b1;
      ST_WB_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_WB_I: ctrl_o.reg_write = 1'b1;
      ST_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_TRAP: ctrl_o.illegal = 1'b1;
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// PA3 multi-cycle control FSM with memory ready handshakes, a wait timeout
// that traps, and a retired-instruction counter.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OpCode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int TW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'((MEM_TO > 0) ? MEM_TO - 1 : 0);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting, rdy, timeout, retire;
  ctrl_t            ctrl, ctrl_g;

  always_comb begin
    waiting = 1'b0;
    rdy     = 1'b0;
    case (state_q)
      ST_FETCH:             begin waiting = 1'b1; rdy = imem_ready; end
      ST_MEM_RD, ST_MEM_WR: begin waiting = 1'b1; rdy = dmem_ready; end
      default:              ;
    endcase
  end

  // A ready arriving on the limit cycle wins over the timeout.
  assign timeout = (MEM_TO != 0) && waiting && !rdy && (timer_q == TO_LIM);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_FETCH:
        if (imem_ready)   state_d = ST_DECODE;
        else if (timeout) state_d = ST_TRAP;
      ST_DECODE: begin
        op_d = OpCode;
        case (OpCode)
          OP_R:               state_d = ST_EXEC_R;
          OP_ADDIU, OP_SUBIU: state_d = ST_EXEC_I;
          OP_SW, OP_LW:       state_d = ST_MEM_ADDR;
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_EXEC_I: state_d = ST_WB_I;
      ST_MEM_ADDR:
        if (op_q == OP_LW)      state_d = ST_MEM_RD;
        else if (op_q == OP_SW) state_d = ST_MEM_WR;
        else                    state_d = ST_TRAP;
      ST_MEM_RD:
        if (dmem_ready)   state_d = ST_WB_MEM;
        else if (timeout) state_d = ST_TRAP;
      ST_MEM_WR:
        if (dmem_ready)   state_d = ST_FETCH;
        else if (timeout) state_d = ST_TRAP;
      ST_WB_R, ST_WB_I, ST_WB_MEM: state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // Staying put in a waiting state only happens while ready is low.
  assign timer_d = (waiting && (state_d == state_q)) ? timer_q + 1'b1 : '0;
  assign retire  = (state_d == ST_FETCH) &&
                   (state_q inside {ST_WB_R, ST_WB_I, ST_WB_MEM, ST_MEM_WR});
  assign cnt_d   = cnt_q + CNT_W'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  ctrl_out_decode u_dec (
    .state_i (state_q),
    .op_i    (op_q),
    .ctrl_o  (ctrl)
  );

  // Reset parks the FSM in FETCH, so strobes need an explicit asynchronous mask.
  always_comb begin
    ctrl_g = ctrl;
    if (!rst_n) ctrl_g = CTRL_IDLE;
  end

  assign imem_req    = ctrl_g.imem_req;
  assign PCWrite     = ctrl_g.fetch_en & imem_ready;
  assign IRWrite     = ctrl_g.fetch_en & imem_ready;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUOp       = ctrl_g.alu_op;
  assign RegDst      = ctrl_g.reg_dst;
  assign ALUSrc      = ctrl_g.alu_src;
  assign MemWrite    = ctrl_g.mem_write;
  assign MemRead     = ctrl_g.mem_read;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign illegal_op  = ctrl_g.illegal;
  assign state       = state_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/strobes/count
// are queued by the stimulus and checked by an independent monitor.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    OpCode;
  logic          imem_ready, dmem_ready;
  logic          imem_req, PCWrite, IRWrite, RegWrite, RegDst, ALUSrc;
  logic          MemWrite, MemRead, MemtoReg, illegal_op;
  logic [1:0]    ALUOp;
  logic [3:0]    state;
  logic [CW-1:0] retired_cnt;

  multicycle_control #(.CNT_W(CW), .MEM_TO(4)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .illegal_op(illegal_op), .state(state), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // {imem_req,PCWrite,IRWrite,RegWrite,ALUOp[1:0],RegDst,ALUSrc,MemWrite,MemRead,MemtoReg,illegal_op}
  localparam logic [11:0] S_RST  = 12'b0000_0100_0000;
  localparam logic [11:0] S_FW   = 12'b1000_0100_0000;
  localparam logic [11:0] S_FGO  = 12'b1110_0100_0000;
  localparam logic [11:0] S_DEC  = 12'b0000_0100_0000;
  localparam logic [11:0] S_EXR  = 12'b0000_1000_0000;
  localparam logic [11:0] S_ADD  = 12'b0000_0101_0000;
  localparam logic [11:0] S_SUB  = 12'b0000_0001_0000;
  localparam logic [11:0] S_MRD  = 12'b0000_0100_0100;
  localparam logic [11:0] S_MWR  = 12'b0000_0100_1000;
  localparam logic [11:0] S_WBR  = 12'b0001_0110_0000;
  localparam logic [11:0] S_WBI  = 12'b0001_0100_0000;
  localparam logic [11:0] S_WBM  = 12'b0001_0100_0010;
  localparam logic [11:0] S_TRAP = 12'b0000_0100_0001;

  typedef struct {
    logic [19:0] v;
    string       nm;
  } exp_t;

  exp_t          sb[$];
  int            compared = 0;
  int            mismatched = 0;
  logic [CW-1:0] exp_cnt = '0;
  event          smp_ev;

  task automatic push(input logic [3:0] st, input logic [11:0] s, input string nm);
    exp_t e;
    e.v  = {st, s, exp_cnt};
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] st, input logic [11:0] s, input string nm);
    push(st, s, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_cnt = '0;
    step(4'd0, S_RST, "reset");
    rst_n = 1'b1;
  endtask

  task automatic run_r();
    OpCode = 6'd4;
    step(4'd0, S_FGO, "r fetch");
    step(4'd1, S_DEC, "r decode");
    step(4'd2, S_EXR, "r exec");
    step(4'd7, S_WBR, "r wb");
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic run_imm(input logic [5:0] op);
    OpCode = op;
    step(4'd0, S_FGO, "imm fetch");
    step(4'd1, S_DEC, "imm decode");
    step(4'd3, (op == 6'd13) ? S_SUB : S_ADD, "imm exec");
    step(4'd8, S_WBI, "imm wb");
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic run_lw(input int waits);
    OpCode = 6'd17;
    step(4'd0, S_FGO, "lw fetch");
    step(4'd1, S_DEC, "lw decode");
    step(4'd4, S_ADD, "lw addr");
    for (int i = 0; i < waits; i++) begin
      dmem_ready = 1'b0;
      step(4'd5, S_MRD, "lw wait");
    end
    dmem_ready = 1'b1;
    step(4'd5, S_MRD, "lw read");
    step(4'd9, S_WBM, "lw wb");
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic run_sw();
    OpCode = 6'd16;
    step(4'd0, S_FGO, "sw fetch");
    step(4'd1, S_DEC, "sw decode");
    step(4'd4, S_ADD, "sw addr");
    step(4'd6, S_MWR, "sw write");
    exp_cnt = exp_cnt + 1'b1;
  endtask

  initial forever begin
    exp_t        e;
    logic [19:0] act;
    @(negedge clk or smp_ev);
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {state, imem_req, PCWrite, IRWrite, RegWrite, ALUOp, RegDst, ALUSrc,
             MemWrite, MemRead, MemtoReg, illegal_op, retired_cnt};
      compared++;
      if (act !== e.v) begin
        mismatched++;
        $display("FAIL %s: got st=%0d ctl=%b cnt=%0d, want st=%0d ctl=%b cnt=%0d",
                 e.nm, act[19:16], act[15:4], act[3:0], e.v[19:16], e.v[15:4], e.v[3:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; OpCode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back traffic with both memories ready unless stated otherwise.
    imem_ready = 1'b1; dmem_ready = 1'b1;
    run_r();
    run_lw(3);                       // ready lands exactly on the timeout limit
    run_sw();
    run_imm(6'd13);
    run_imm(6'd12);

    // Illegal opcode: absorbing trap, counter held, ready inputs ignored.
    OpCode = 6'd5;
    step(4'd0, S_FGO, "bad fetch");
    step(4'd1, S_DEC, "bad decode");
    for (int i = 0; i < 20; i++) step(4'd10, S_TRAP, "bad trap");
    do_reset();

    // Data memory never answers a store.
    OpCode = 6'd16;
    step(4'd0, S_FGO, "swto fetch");
    step(4'd1, S_DEC, "swto decode");
    step(4'd4, S_ADD, "swto addr");
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(4'd6, S_MWR, "swto wait");
    for (int i = 0; i < 3; i++) step(4'd10, S_TRAP, "swto trap");

    // Instruction memory never answers.
    imem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step(4'd0, S_FW, "ifto wait");
    for (int i = 0; i < 2; i++) step(4'd10, S_TRAP, "ifto trap");

    // Counter wrap, then reset mid EXEC_I without a clock edge.
    do_reset();
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 17; i++) run_imm(6'd12);
    OpCode = 6'd12;
    step(4'd0, S_FGO, "abort fetch");
    step(4'd1, S_DEC, "abort decode");
    push(4'd3, S_ADD, "abort exec");
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    exp_cnt = '0;
    #1;
    push(4'd0, S_RST, "async reset");
    -> smp_ev;
    @(posedge clk);
    #1;
    step(4'd0, S_RST, "reset held");
    rst_n = 1'b1;
    run_imm(6'd12);

    @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
